multdiv: RTL

MULTDIV -- requirements
Module: multdiv

---
 rtl/multdiv.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/multdiv.sv
// Iterative signed 32x32 multiplier (radix-2 Booth) and signed divider (restoring on magnitudes).
// One start pulse launches an operation; data_resultRDY pulses LATENCY edges after the start edge.
module multdiv #(
    parameter int LATENCY = 33
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

    localparam int ITERS = 32;
    // Setup cycles between the start edge and the first iteration; at least one.
    localparam int PRE = (LATENCY > ITERS) ? LATENCY - ITERS : 1;
    localparam logic [7:0] PRE_LAST  = 8'(PRE - 1);
    localparam logic [4:0] LAST_ITER = 5'd31;

    state_t      state;
    logic [4:0]  count;
    logic [7:0]  pre_count;
    logic        iterating;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [32:0] acc;
    logic [32:0] m;
    logic [31:0] mq;
    logic        qm1;
    logic        neg_q;

    logic        start;
    logic [32:0] sum;
    logic [32:0] rem_shift;
    logic [32:0] step_acc;
    logic [31:0] step_mq;
    logic        step_qm1;
    logic [63:0] product;
    logic        mult_ovf;
    logic        div_zero;
    logic        div_ovf;
    logic [31:0] quotient;
    logic [31:0] mag_a;
    logic [31:0] mag_b;

    assign start = ctrl_MULT | ctrl_DIV;

    // One iteration of either algorithm; {acc, mq, qm1} is the shared working register.
    always_comb begin
        sum       = acc;
        rem_shift = '0;
        step_acc  = acc;
        step_mq   = mq;
        step_qm1  = qm1;
        if (state == MULT) begin
            case ({mq[0], qm1})
                2'b01:   sum = acc + m;
                2'b10:   sum = acc - m;
                default: sum = acc;
            endcase
            step_acc = {sum[32], sum[32:1]};
            step_mq  = {sum[0], mq[31:1]};
            step_qm1 = mq[0];
        end else begin
            rem_shift = {acc[31:0], mq[31]};
            if (rem_shift >= m) begin
                step_acc = rem_shift - m;
                step_mq  = {mq[30:0], 1'b1};
            end else begin
                step_acc = rem_shift;
                step_mq  = {mq[30:0], 1'b0};
            end
        end
    end

    assign product  = {step_acc[31:0], step_mq};
    assign mult_ovf = ~((&product[63:31]) | ~(|product[63:31]));
    assign div_zero = (op_b == 32'd0);
    assign div_ovf  = (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
    assign quotient = neg_q ? -step_mq : step_mq;
    // -2^31 negates to itself, which read as unsigned is the correct magnitude.
    assign mag_a    = op_a[31] ? -op_a : op_a;
    assign mag_b    = op_b[31] ? -op_b : op_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            count          <= '0;
            pre_count      <= '0;
            iterating      <= 1'b0;
            op_a           <= '0;
            op_b           <= '0;
            acc            <= '0;
            m              <= '0;
            mq             <= '0;
            qm1            <= 1'b0;
            neg_q          <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (start) begin
                state     <= ctrl_MULT ? MULT : DIV;
                op_a      <= data_operandA;
                op_b      <= data_operandB;
                count     <= '0;
                pre_count <= '0;
                iterating <= 1'b0;
            end else begin
                case (state)
                    IDLE: ;
                    MULT, DIV: begin
                        if (!iterating) begin
                            acc   <= '0;
                            qm1   <= 1'b0;
                            neg_q <= op_a[31] ^ op_b[31];
                            if (state == MULT) begin
                                mq <= op_b;
                                m  <= {op_a[31], op_a};
                            end else begin
                                mq <= mag_a;
                                m  <= {1'b0, mag_b};
                            end
                            if (pre_count == PRE_LAST) iterating <= 1'b1;
                            else pre_count <= pre_count + 8'd1;
                        end else begin
                            acc   <= step_acc;
                            mq    <= step_mq;
                            qm1   <= step_qm1;
                            count <= count + 5'd1;
                            if (count == LAST_ITER) begin
                                state          <= DONE;
                                data_resultRDY <= 1'b1;
                                if (state == MULT) begin
                                    data_result    <= product[31:0];
                                    data_exception <= mult_ovf;
                                end else if (div_zero || div_ovf) begin
                                    data_result    <= '0;
                                    data_exception <= 1'b1;
                                end else begin
                                    data_result    <= quotient;
                                    data_exception <= 1'b0;
                                end
                            end
                        end
                    end
                    DONE: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
